// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the banked register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DEF_W / DEF_D / DEF_NR : default width, address width and read-port count
//   copy_state_e           : state of the main<->shadow bank copy engine
package reg_file_pkg;

  localparam int DEF_W  = 8;
  localparam int DEF_D  = 4;
  localparam int DEF_NR = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } copy_state_e;

  // Every state except IDLE holds the register file away from the user.
  function automatic logic state_is_busy(input copy_state_e s);
    return (s != ST_IDLE);
  endfunction

endpackage

// File: rtl/reg_file_copy_ctrl.sv
// Sequencer for bulk main->shadow (save) and shadow->main (restore) copies.
// Latency: one register per cycle, done pulses in the (2**D+1)th cycle after the request edge.
// Backpressure: requests arriving while busy are dropped, not queued.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   save_req            : start main->shadow copy (wins over restore_req)
//   restore_req         : start shadow->main copy
//   busy                : copy sequence in progress (SAVE, RESTORE, DONE)
//   done                : single-cycle pulse in the DONE state
//   idx                 : register currently being copied
//   save_active         : shadow[idx] <= main[idx] this cycle
//   restore_active      : main[idx] <= shadow[idx] this cycle
module reg_file_copy_ctrl
  import reg_file_pkg::*;
#(
  parameter int D = DEF_D
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         save_req,
  input  logic         restore_req,
  output logic         busy,
  output logic         done,
  output logic [D-1:0] idx,
  output logic         save_active,
  output logic         restore_active
);

  localparam logic [D-1:0] IDX_LAST = {D{1'b1}};

  copy_state_e  state_q;
  copy_state_e  state_d;
  logic [D-1:0] idx_q;
  logic [D-1:0] idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    done           = 1'b0;
    save_active    = 1'b0;
    restore_active = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (save_req) begin
          state_d = ST_SAVE;
        end else if (restore_req) begin
          state_d = ST_RESTORE;
        end
      end

      ST_SAVE: begin
        save_active = 1'b1;
        idx_d       = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_RESTORE: begin
        restore_active = 1'b1;
        idx_d          = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Extra cycle so done lands one cycle after the last copy; index is
        // forced back to 0 so the next sequence always starts at register 0.
        done    = 1'b1;
        idx_d   = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy = state_is_busy(state_q);
  assign idx  = idx_q;

endmodule

// File: rtl/reg_file_banked.sv
// Register file with a main bank, a shadow bank and bulk save/restore.
// Latency: reads combinational (optional same-cycle write forwarding); writes land at next edge.
// Backpressure: writes, moves and save/restore requests are dropped while busy.
//
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   wr_en, wr_data          : write wr_data into main[wr_addr]
//   mov_en, mov_src         : copy main[mov_src] into main[wr_addr] (beats wr_en)
//   wr_addr                 : destination register for write/move
//   rd_addr[NR], rd_data[NR]: independent combinational read ports
//   acc_out                 : main[0], always visible
//   save_req, restore_req   : start main->shadow / shadow->main copy
//   busy, done              : copy in progress / end-of-copy pulse
module reg_file_banked
  import reg_file_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int D      = DEF_D,
  parameter int NR     = DEF_NR,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  mov_en,
  input  logic [D-1:0]          wr_addr,
  input  logic [D-1:0]          mov_src,
  input  logic [W-1:0]          wr_data,
  input  logic [NR-1:0][D-1:0]  rd_addr,
  output logic [NR-1:0][W-1:0]  rd_data,
  output logic [W-1:0]          acc_out,
  input  logic                  save_req,
  input  logic                  restore_req,
  output logic                  busy,
  output logic                  done
);

  localparam int N = 1 << D;

  logic [W-1:0] main_q   [N];
  logic [W-1:0] shadow_q [N];

  logic         save_active;
  logic         restore_active;
  logic [D-1:0] idx;

  logic         wr_acc;
  logic [W-1:0] wr_val;
  logic         byp_en;

  reg_file_copy_ctrl #(
    .D (D)
  ) u_copy_ctrl (
    .clk            (clk),
    .reset          (reset),
    .save_req       (save_req),
    .restore_req    (restore_req),
    .busy           (busy),
    .done           (done),
    .idx            (idx),
    .save_active    (save_active),
    .restore_active (restore_active)
  );

  // A move reads the source from the current main bank, so a self-move
  // rewrites the same value and the register is left unchanged.
  assign wr_acc = (wr_en | mov_en) & ~busy;
  assign wr_val = mov_en ? main_q[mov_src] : wr_data;
  assign byp_en = (BYPASS != 0) && wr_acc;

  // Forwarding only applies to accepted writes, so nothing is forwarded
  // while a copy sequence owns the banks.
  for (genvar i = 0; i < NR; i++) begin : g_rd
    assign rd_data[i] = (byp_en && (rd_addr[i] == wr_addr)) ? wr_val
                                                             : main_q[rd_addr[i]];
  end

  assign acc_out = (byp_en && (wr_addr == '0)) ? wr_val : main_q[0];

  // Main bank: restore and user writes never overlap because user writes
  // are only accepted outside the copy sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        main_q[k] <= '0;
      end
    end else if (restore_active) begin
      main_q[idx] <= shadow_q[idx];
    end else if (wr_acc) begin
      main_q[wr_addr] <= wr_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (save_active) begin
      shadow_q[idx] <= main_q[idx];
    end
  end

endmodule

// File: doc/reg_file_banked.md
REG_FILE_BANKED -- requirements
Module: reg_file_banked

Interface
REQ-001 SHALL have parameter W, default 8: register width in bits.
REQ-002 SHALL have parameter D, default 4: address width; 2**D registers per bank.
REQ-003 SHALL have parameter NR, default 2: number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1: 1 forwards accepted write data to same-address reads.
REQ-005 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1: write wr_data into main[wr_addr].
REQ-008 SHALL have port mov_en  input  1: copy main[mov_src] into main[wr_addr].
REQ-009 SHALL have port wr_addr  input  D: destination register.
REQ-010 SHALL have port mov_src  input  D: move source register.
REQ-011 SHALL have port wr_data  input  W: write data.
REQ-012 SHALL have port rd_addr  input  NR x D: per-port read address.
REQ-013 SHALL have port rd_data  output  NR x W: per-port read data.
REQ-014 SHALL have port acc_out  output  W: main[0], always visible.
REQ-015 SHALL have port save_req  input  1: start copy of main bank to shadow bank.
REQ-016 SHALL have port restore_req  input  1: start copy of shadow bank to main bank.
REQ-017 SHALL have port busy  output  1: save/restore in progress.
REQ-018 SHALL have port done  output  1: one-cycle pulse at end of save/restore.

Function
REQ-019 rd_data[i] SHALL be combinational main[rd_addr[i]], except as REQ-021 states.
REQ-020 Write accepted = (wr_en or mov_en) and not busy; mov_en SHALL take priority over wr_en; both update main[wr_addr] at next edge.
REQ-021 With BYPASS=1 and an accepted write, rd_data[i] and acc_out SHALL show the value being written (wr_data, or main[mov_src] for a move) when their address equals wr_addr; with BYPASS=0 they SHALL show the old value.
REQ-022 A move with mov_src == wr_addr SHALL leave the register unchanged.
REQ-023 FSM states: IDLE, SAVE, RESTORE, DONE.
REQ-024 IDLE: save_req -> SAVE; restore_req only -> RESTORE; both asserted -> SAVE (save wins).
REQ-025 SAVE/RESTORE: D-bit index counter starts at 0 and copies one register per cycle (shadow[idx]<=main[idx] or main[idx]<=shadow[idx]); at idx == 2**D-1 the state SHALL go to DONE.
REQ-026 Copy latency: done SHALL pulse exactly 2**D+1 cycles after the request edge; DONE -> IDLE unconditionally.
REQ-027 busy SHALL be 1 in SAVE, RESTORE and DONE, 0 in IDLE.
REQ-028 While busy, wr_en/mov_en SHALL be ignored (no update, no bypass), and save_req/restore_req SHALL be ignored, not queued.
REQ-029 Reads during RESTORE SHALL return current main contents (partially restored registers visible).
REQ-030 The index counter SHALL wrap to 0 on leaving DONE.

Reset
REQ-031 Reset SHALL asynchronously clear all main and shadow registers to 0, FSM to IDLE, index to 0, busy=0, done=0; rd_data and acc_out read 0.
REQ-032 Reset during SAVE/RESTORE SHALL abort immediately, with no done pulse after reset release.
REQ-033 The first accepted write SHALL be the one at the first rising edge after reset deasserts.

Structure
REQ-034 Package reg_file_pkg SHALL hold the FSM state enum and default W/D/NR constants.
REQ-035 Sub-module reg_file_copy_ctrl SHALL contain the FSM and index counter and output busy, done, idx, save_active and restore_active; the register arrays and port logic stay in the top module.

Verification
REQ-036 Write 0x5A to r3, read r3 on port 0 and port 1 the next cycle -> both return 0x5A; acc_out 0.
REQ-037 BYPASS=1: wr_en to r2 = 0x11 with rd_addr[0]=2 in the same cycle -> rd_data[0]=0x11 before the edge; BYPASS=0 -> old value 0x00.
REQ-038 r1=0x22, mov_en mov_src=1 wr_addr=0 with wr_en=1 wr_data=0xFF -> r0=0x22, acc_out=0x22.
REQ-039 r0..r15=i+1; save; overwrite all with 0; restore -> done 17 cycles after each request, r7=0x08, writes during busy dropped.
REQ-040 save_req and restore_req asserted together in IDLE -> SAVE taken, shadow=main; reset asserted at idx=5 -> busy 0 at once, all registers 0, no done pulse.
